// File: rtl/mem_pkg.sv
// Shared widths, defaults and the MEM/WB control bundle for the memory stage.
package mem_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;
  localparam int REG_AW     = 5;

  // Write-back controls carried through the MEM/WB register
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } memwb_ctrl_t;
endpackage

// File: rtl/data_mem.sv
// Single-port word RAM: synchronous write, asynchronous read, zero at time 0.
// A read of the index being written returns the old word (read-before-write).
module data_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

  // Word write on the rising edge; contents untouched by reset
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory access, branch/jump resolve, MEM/WB register and
// write-back mux. Optional macro MEM_ALIGN_CHECK_EN enables the sticky
// misaligned-access detector (store suppression, write-back kill).
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Flush,
  input  logic              ExMem_Jump,
  input  logic              ExMem_Branch,
  input  logic              ExMem_MemRead,
  input  logic              ExMem_MemtoReg,
  input  logic              ExMem_MemWrite,
  input  logic              ExMem_RegWrite,
  input  logic [DATA_W-1:0] ExMem_AluOut,
  input  logic [DATA_W-1:0] ExMem_DataRt,
  input  logic [REG_AW-1:0] ExMem_AddrRdRt,
  input  logic              ExMem_ZeroFlag,
  output logic              PCSrc,
  output logic              PCJump,
  output logic              MemWb_RegWrite,
  output logic              MemWb_MemtoReg,
  output logic [DATA_W-1:0] MemWb_ReadData,
  output logic [DATA_W-1:0] MemWb_AluOut,
  output logic [REG_AW-1:0] MemWb_AddrRdRt,
  output logic [DATA_W-1:0] Dst_FeedBack,
  output logic              Misalign_Err,
  output logic [DATA_W-1:0] Misalign_Addr
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     w_idx;
  logic [DATA_W-1:0] w_rdata;
  logic              w_mis;
  logic              w_we;
  memwb_ctrl_t       w_ctrl_nxt;
  memwb_ctrl_t       r_ctrl;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_alu;
  logic [REG_AW-1:0] r_rd;

  // Upper address bits dropped: accesses wrap modulo DEPTH
  assign w_idx = ExMem_AluOut[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic              r_mis_err;
  logic [DATA_W-1:0] r_mis_addr;

  assign w_mis = (ExMem_MemRead | ExMem_MemWrite) & (ExMem_AluOut[1:0] != 2'b00) & ~Flush;

  // Sticky flag; address latched only for the first offending access
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_mis_err  <= 1'b0;
      r_mis_addr <= '0;
    end else if (w_mis && !r_mis_err) begin
      r_mis_err  <= 1'b1;
      r_mis_addr <= ExMem_AluOut;
    end
  end

  assign Misalign_Err  = r_mis_err;
  assign Misalign_Addr = r_mis_addr;
`else
  assign w_mis         = 1'b0;
  assign Misalign_Err  = 1'b0;
  assign Misalign_Addr = '0;
`endif

  // A flushed or misaligned store must leave memory untouched
  assign w_we = ExMem_MemWrite & ~Flush & ~w_mis;

  data_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dmem (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (ExMem_DataRt),
    .o_rdata (w_rdata)
  );

  assign PCSrc  = ExMem_Branch & ExMem_ZeroFlag & ~Flush;
  assign PCJump = ExMem_Jump & ~Flush;

  // Flush kills both controls; misalignment only kills the register write
  always_comb begin
    w_ctrl_nxt.reg_write  = ExMem_RegWrite & ~Flush & ~w_mis;
    w_ctrl_nxt.mem_to_reg = ExMem_MemtoReg & ~Flush;
  end

  // MEM/WB register: data fields load every edge, even when flushed
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_ctrl  <= '0;
      r_rdata <= '0;
      r_alu   <= '0;
      r_rd    <= '0;
    end else begin
      r_ctrl  <= w_ctrl_nxt;
      r_rdata <= w_rdata;
      r_alu   <= ExMem_AluOut;
      r_rd    <= ExMem_AddrRdRt;
    end
  end

  assign MemWb_RegWrite = r_ctrl.reg_write;
  assign MemWb_MemtoReg = r_ctrl.mem_to_reg;
  assign MemWb_ReadData = r_rdata;
  assign MemWb_AluOut   = r_alu;
  assign MemWb_AddrRdRt = r_rd;
  assign Dst_FeedBack   = r_ctrl.mem_to_reg ? r_rdata : r_alu;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; align-check vectors switch on MEM_ALIGN_CHECK_EN.
module tb_mem_wb_stage;
  logic        CLK = 1'b0;
  logic        RST_n, Flush;
  logic        ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg;
  logic        ExMem_MemWrite, ExMem_RegWrite, ExMem_ZeroFlag;
  logic [31:0] ExMem_AluOut, ExMem_DataRt;
  logic [4:0]  ExMem_AddrRdRt;
  logic        PCSrc, PCJump, MemWb_RegWrite, MemWb_MemtoReg, Misalign_Err;
  logic [31:0] MemWb_ReadData, MemWb_AluOut, Dst_FeedBack, Misalign_Addr;
  logic [4:0]  MemWb_AddrRdRt;

  int n_chk = 0;
  int n_ok  = 0;

  mem_wb_stage dut (
    .CLK(CLK), .RST_n(RST_n), .Flush(Flush),
    .ExMem_Jump(ExMem_Jump), .ExMem_Branch(ExMem_Branch),
    .ExMem_MemRead(ExMem_MemRead), .ExMem_MemtoReg(ExMem_MemtoReg),
    .ExMem_MemWrite(ExMem_MemWrite), .ExMem_RegWrite(ExMem_RegWrite),
    .ExMem_AluOut(ExMem_AluOut), .ExMem_DataRt(ExMem_DataRt),
    .ExMem_AddrRdRt(ExMem_AddrRdRt), .ExMem_ZeroFlag(ExMem_ZeroFlag),
    .PCSrc(PCSrc), .PCJump(PCJump),
    .MemWb_RegWrite(MemWb_RegWrite), .MemWb_MemtoReg(MemWb_MemtoReg),
    .MemWb_ReadData(MemWb_ReadData), .MemWb_AluOut(MemWb_AluOut),
    .MemWb_AddrRdRt(MemWb_AddrRdRt), .Dst_FeedBack(Dst_FeedBack),
    .Misalign_Err(Misalign_Err), .Misalign_Addr(Misalign_Addr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One EX/MEM bundle: {write, read, memtoreg, regwrite, flush}
  task automatic drive(input logic wr, input logic rd, input logic m2r, input logic rw,
                       input logic fl, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rdst);
    ExMem_MemWrite = wr; ExMem_MemRead = rd; ExMem_MemtoReg = m2r;
    ExMem_RegWrite = rw; Flush = fl; ExMem_AluOut = addr; ExMem_DataRt = data;
    ExMem_AddrRdRt = rdst;
  endtask

  initial begin
    RST_n = 1'b0;
    ExMem_Jump = 0; ExMem_Branch = 0; ExMem_ZeroFlag = 0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    #2;
    chk("rst_regwrite", {31'b0, MemWb_RegWrite}, 32'd0);
    chk("rst_dst",      Dst_FeedBack, 32'd0);
    chk("rst_misalign", {31'b0, Misalign_Err}, 32'd0);
    #5 RST_n = 1'b1;   // released after the first edge
    tick();

    // store then load
    drive(1, 0, 0, 0, 0, 32'd8, 32'hDEADBEEF, 5'd0);
    tick();
    chk("st_regwrite", {31'b0, MemWb_RegWrite}, 32'd0);
    drive(0, 1, 1, 1, 0, 32'd8, 32'h0, 5'd5);
    tick();
    chk("ld_rdata", MemWb_ReadData, 32'hDEADBEEF);
    chk("ld_dst",   Dst_FeedBack,   32'hDEADBEEF);
    chk("ld_rd",    {27'b0, MemWb_AddrRdRt}, 32'd5);
    chk("ld_regwr", {31'b0, MemWb_RegWrite}, 32'd1);

    // R-type pass-through
    drive(0, 0, 0, 1, 0, 32'd54, 32'h0, 5'd9);
    tick();
    chk("pass_dst", Dst_FeedBack, 32'd54);
    chk("pass_rd",  {27'b0, MemWb_AddrRdRt}, 32'd9);

    // flushed store leaves memory and write-back untouched
    drive(1, 0, 0, 0, 0, 32'd12, 32'd3, 5'd0);
    tick();
    drive(1, 0, 1, 1, 1, 32'd12, 32'd7, 5'd3);
    tick();
    chk("fl_regwr", {31'b0, MemWb_RegWrite}, 32'd0);
    chk("fl_m2r",   {31'b0, MemWb_MemtoReg}, 32'd0);
    chk("fl_alu",   MemWb_AluOut, 32'd12);
    drive(0, 1, 1, 1, 0, 32'd12, 32'h0, 5'd4);
    tick();
    chk("fl_load", MemWb_ReadData, 32'd3);

    // branch / jump resolve, combinational
    ExMem_Branch = 1; ExMem_ZeroFlag = 1; #1;
    chk("br_taken", {31'b0, PCSrc}, 32'd1);
    ExMem_ZeroFlag = 0; #1;
    chk("br_nz", {31'b0, PCSrc}, 32'd0);
    ExMem_ZeroFlag = 1; Flush = 1; #1;
    chk("br_flush", {31'b0, PCSrc}, 32'd0);
    ExMem_Jump = 1; #1;
    chk("jmp_flush", {31'b0, PCJump}, 32'd0);
    Flush = 0; #1;
    chk("jmp", {31'b0, PCJump}, 32'd1);
    ExMem_Jump = 0; ExMem_Branch = 0; ExMem_ZeroFlag = 0;

    // read-before-write on the same index
    drive(1, 0, 0, 0, 0, 32'd16, 32'h1111, 5'd0);
    tick();
    drive(1, 1, 1, 1, 0, 32'd16, 32'h2222, 5'd1);
    tick();
    chk("rbw_old", MemWb_ReadData, 32'h1111);
    drive(0, 1, 1, 1, 0, 32'd16, 32'h0, 5'd1);
    tick();
    chk("rbw_new", MemWb_ReadData, 32'h2222);

    // index wraps modulo DEPTH (256 words = 1024 bytes)
    drive(1, 0, 0, 0, 0, 32'd1044, 32'hABCD, 5'd0);
    tick();
    drive(0, 1, 1, 1, 0, 32'd20, 32'h0, 5'd2);
    tick();
    chk("wrap", Dst_FeedBack, 32'hABCD);

    // misaligned store to 6 targets word at byte 4
    drive(1, 0, 0, 0, 0, 32'd4, 32'hAA, 5'd0);
    tick();
    drive(1, 0, 0, 1, 0, 32'd6, 32'h55, 5'd7);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_err",   {31'b0, Misalign_Err}, 32'd1);
    chk("mis_addr",  Misalign_Addr, 32'd6);
    chk("mis_regwr", {31'b0, MemWb_RegWrite}, 32'd0);
    drive(0, 1, 1, 1, 0, 32'd4, 32'h0, 5'd7);
    tick();
    chk("mis_word4", MemWb_ReadData, 32'hAA);
    drive(0, 1, 1, 1, 0, 32'd9, 32'h0, 5'd7);
    tick();
    chk("mis_first", Misalign_Addr, 32'd6);
    chk("mis_stick", {31'b0, Misalign_Err}, 32'd1);
`else
    chk("noal_err",   {31'b0, Misalign_Err}, 32'd0);
    chk("noal_regwr", {31'b0, MemWb_RegWrite}, 32'd1);
    drive(0, 1, 1, 1, 0, 32'd4, 32'h0, 5'd7);
    tick();
    chk("noal_word4", MemWb_ReadData, 32'h55);
    chk("noal_addr",  Misalign_Addr, 32'd0);
`endif

    // asynchronous reset mid-cycle while outputs are non-zero
    drive(0, 1, 1, 1, 0, 32'd8, 32'h0, 5'd5);
    tick();
    chk("pre_rst_dst", Dst_FeedBack, 32'hDEADBEEF);
    #2 RST_n = 1'b0;
    #1;
    chk("arst_dst",   Dst_FeedBack, 32'd0);
    chk("arst_rdata", MemWb_ReadData, 32'd0);
    chk("arst_rd",    {27'b0, MemWb_AddrRdRt}, 32'd0);
    chk("arst_m2r",   {31'b0, MemWb_MemtoReg}, 32'd0);
    chk("arst_err",   {31'b0, Misalign_Err}, 32'd0);
    // PCJump still live during reset
    ExMem_Jump = 1; #1;
    chk("rst_jmp", {31'b0, PCJump}, 32'd1);
    ExMem_Jump = 0;
    @(negedge CLK);
    RST_n = 1'b1;
    drive(0, 0, 0, 1, 0, 32'd77, 32'h0, 5'd3);
    tick();
    chk("post_rst", Dst_FeedBack, 32'd77);
    chk("post_regwr", {31'b0, MemWb_RegWrite}, 32'd1);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage of the 5-stage pipelined RISC core. It consumes the EX/MEM pipeline register produced by the ALU stage and performs data-memory loads and stores. It also resolves the branch/jump decision for the fetch stage and registers the MEM/WB bundle. It drives `Dst_FeedBack`, the write-back value the register file writes and the ALU stage forwards on `FwdRs`/`FwdRt` = 01.

## Interface
Parameters:
- `DATA_W`, 32: datapath width.
- `DEPTH`, 256: data-memory depth in 32-bit words; power of two.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_n` in 1: reset, asynchronous and active-low.
- `Flush` in 1: kill the instruction currently in MEM.
- `ExMem_Jump`, `ExMem_Branch`, `ExMem_MemRead`, `ExMem_MemtoReg`, `ExMem_MemWrite`, `ExMem_RegWrite` in 1 each: control bits from the EX/MEM register.
- `ExMem_AluOut` in 32: effective address, or ALU result.
- `ExMem_DataRt` in 32: store data.
- `ExMem_AddrRdRt` in 5: destination register.
- `ExMem_ZeroFlag` in 1: ALU zero flag.
- `PCSrc` out 1: branch taken.
- `PCJump` out 1: jump taken.
- `MemWb_RegWrite`, `MemWb_MemtoReg` out 1 each: registered write-back controls.
- `MemWb_ReadData` out 32: registered load data.
- `MemWb_AluOut` out 32: registered ALU result.
- `MemWb_AddrRdRt` out 5: registered destination register.
- `Dst_FeedBack` out 32: write-back value.
- `Misalign_Err` out 1: sticky misalignment flag; only meaningful with `MEM_ALIGN_CHECK_EN`.
- `Misalign_Addr` out 32: first misaligned address; only meaningful with `MEM_ALIGN_CHECK_EN`.

## Operation
- Word index is `ExMem_AluOut[log2(DEPTH)+1:2]`.
  - Upper address bits are ignored, so accesses wrap modulo DEPTH.
  - Bits [1:0] are ignored unless the align check is compiled in.
- Store: if `ExMem_MemWrite`=1 and `Flush`=0, then `mem[idx] <= ExMem_DataRt` at the rising edge.
- Load: read is combinational from `mem[idx]` and captured into `MemWb_ReadData` at the edge.
  - `MemWb_ReadData` is captured every cycle, regardless of `ExMem_MemRead`.
- Read and write to the same index in the same cycle: the read returns the old data (read-before-write).
- Memory contents are not affected by reset; they are zero-initialised at time 0.
- `PCSrc = ExMem_Branch & ExMem_ZeroFlag & ~Flush` (combinational).
- `PCJump = ExMem_Jump & ~Flush` (combinational).
- MEM/WB register:
  - Captures `AluOut`, `AddrRdRt`, `RegWrite` and `MemtoReg` every edge.
  - When `Flush`=1, `MemWb_RegWrite` and `MemWb_MemtoReg` load 0; data fields load normally.
- `Dst_FeedBack = MemWb_MemtoReg ? MemWb_ReadData : MemWb_AluOut` (combinational from registers).

## Timing
- Reset (`RST_n`=0, asynchronous): every `MemWb_*` output, `Misalign_Err` and `Misalign_Addr` go to 0, so `Dst_FeedBack` = 0.
- `PCSrc` and `PCJump` depend only on their inputs and are valid during reset.
- Latency: EX/MEM inputs appear on the `MemWb_*` outputs and `Dst_FeedBack` exactly 1 cycle later.
- A store at edge N is visible to a load sampled at edge N+1.
- Reset deasserted mid-stream: the first valid MEM/WB capture is at the first rising edge after release.
- Flush and store in the same cycle: the store is suppressed and write-back is suppressed. No memory side effect.

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- When defined, an access with `MemRead`|`MemWrite`, `ExMem_AluOut[1:0]`≠0 and `Flush`=0 is misaligned:
  - the store is suppressed;
  - `MemWb_RegWrite` loads 0;
  - `Misalign_Err` sets and stays 1 until reset;
  - `Misalign_Addr` captures the address of the first such access only.
- When undefined: bits [1:0] are ignored, and `Misalign_Err`/`Misalign_Addr` are tied to 0.

## Structure
- `mem_pkg` holds:
  - `DATA_W`;
  - the default `DEPTH`;
  - register-address width (5);
  - a packed struct for the MEM/WB control bundle (`RegWrite`, `MemtoReg`).
- One sub-module, `data_mem`: single-port word RAM with synchronous write, asynchronous read and zero init.
- The pipeline register, branch logic, align check and write-back mux live in `mem_wb_stage`.

## Test plan
- Reset: assert `RST_n`=0 mid-cycle → all `MemWb_*` outputs = 0 and `Dst_FeedBack` = 0 immediately, without waiting for a clock edge.
- Store then load:
  - Cycle 1: store `DataRt`=0xDEADBEEF to `AluOut`=8.
  - Cycle 2: load `AluOut`=8 with `MemtoReg`=1, `RegWrite`=1, `AddrRdRt`=5.
  - Expect after edge 2: `MemWb_ReadData` = `Dst_FeedBack` = 0xDEADBEEF, `MemWb_AddrRdRt`=5.
- Pass-through: R-type with `AluOut`=54, `MemtoReg`=0, `RegWrite`=1 → `Dst_FeedBack`=54 one cycle later.
- Flushed store:
  - Store 3 to address 12.
  - Store 7 to address 12 with `Flush`=1 → `MemWb_RegWrite`=0.
  - Then load address 12 → `MemWb_ReadData`=3.
- Branch:
  - `Branch`=1, `Zero`=1 → `PCSrc`=1 in the same cycle.
  - `Zero`=0 → `PCSrc`=0.
  - `Branch`=1, `Zero`=1, `Flush`=1 → `PCSrc`=0.
- Align check (`MEM_ALIGN_CHECK_EN` defined):
  - Store 0x55 to address 6 → `Misalign_Err`=1, `Misalign_Addr`=6, word 4 unchanged.
  - A later misaligned access to address 9 leaves `Misalign_Addr`=6.
